simon_sequence_player: RTL

Pattern source for the Simon Says game. Generates a pseudo-random sequence of 2-bit button symbols, stores up to MAX_LEN of them, and plays the current sequence to the player as timed LED flashes. It exposes a combinational read port so the answer checker, which consumes `knapp_comb` and drives `correct_out` and `count_out`, can compare each entry against the stored symbol at a given index.

---
 rtl/simon_sequence_player.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/simon_sequence_player.sv
// Simon Says pattern source: grows a pseudo-random sequence of 2-bit symbols,
// replays it as timed LED flashes and offers a combinational read port for
// the answer checker.
//
// state | meaning
// IDLE  | waiting for start/extend, LED dark
// SHOW  | symbol mem[idx] lit for ON_CYCLES cycles
// GAP   | dark pause of OFF_CYCLES cycles after each symbol
module simon_sequence_player #(
  parameter int          MAX_LEN    = 32,
  parameter int          ON_CYCLES  = 4,
  parameter int          OFF_CYCLES = 2,
  parameter logic [7:0]  SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       extend,
  input  logic [5:0] rd_idx,
  output logic [1:0] rd_sym,
  output logic       led_on,
  output logic [1:0] led_sym,
  output logic       play_busy,
  output logic       play_done,
  output logic [5:0] seq_len,
  output logic       full
);

  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  // tcnt only has to reach TMAX-1 before the phase ends
  localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
  localparam logic [5:0]    LEN_MAX  = 6'(MAX_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

  state_t          state_q, state_d;
  logic [5:0]      seq_len_q, seq_len_d;
  logic [5:0]      idx_q, idx_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            play_done_q, play_done_d;
  logic [1:0]      mem_q [MAX_LEN];
  logic [1:0]      mem_d [MAX_LEN];
  logic            wr_en;
  logic [5:0]      wr_addr;
  logic            full_w;

  assign full_w = (seq_len_q == LEN_MAX);

  // Sequencer: command acceptance, dwell timing and playback index
  always_comb begin
    state_d     = state_q;
    seq_len_d   = seq_len_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    play_done_d = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = seq_len_q;
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (start) begin
      // a new game overrides anything in flight, including a pending done
      wr_en     = 1'b1;
      wr_addr   = 6'd0;
      seq_len_d = 6'd1;
      idx_d     = 6'd0;
      tcnt_d    = '0;
      state_d   = ST_SHOW;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (extend && (seq_len_q != 6'd0)) begin
            if (!full_w) begin
              wr_en     = 1'b1;
              wr_addr   = seq_len_q;
              seq_len_d = seq_len_q + 6'd1;
            end
            idx_d   = 6'd0;
            tcnt_d  = '0;
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (tcnt_q == ON_LAST) begin
            tcnt_d  = '0;
            state_d = ST_GAP;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        ST_GAP: begin
          if (tcnt_q == OFF_LAST) begin
            tcnt_d = '0;
            if (idx_q == seq_len_q - 6'd1) begin
              state_d     = ST_IDLE;
              play_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + 6'd1;
              state_d = ST_SHOW;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Symbol store write: the appended symbol is the LFSR value before this edge
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      mem_d[i] = (wr_en && (wr_addr == 6'(i))) ? lfsr_q[1:0] : mem_q[i];
    end
  end

  // Read muxes for the checker port and the LED display
  always_comb begin
    rd_sym  = 2'b00;
    led_sym = 2'b00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((rd_idx == 6'(i)) && (rd_idx < seq_len_q)) rd_sym = mem_q[i];
      if ((state_q == ST_SHOW) && (idx_q == 6'(i)))  led_sym = mem_q[i];
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      seq_len_q   <= 6'd0;
      idx_q       <= 6'd0;
      tcnt_q      <= '0;
      lfsr_q      <= SEED;
      play_done_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= 2'b00;
    end else begin
      state_q     <= state_d;
      seq_len_q   <= seq_len_d;
      idx_q       <= idx_d;
      tcnt_q      <= tcnt_d;
      lfsr_q      <= lfsr_d;
      play_done_q <= play_done_d;
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign led_on    = (state_q == ST_SHOW);
  assign play_busy = (state_q != ST_IDLE);
  assign play_done = play_done_q;
  assign seq_len   = seq_len_q;
  assign full      = full_w;

endmodule
